draw_rect_ctl: RTL and testbench

- Position controller directly upstream of the rectangle-drawing stage; produces the `xpos`/`ypos` that the drawing stage consumes.
- Follows the mouse until a left click, then drops the rectangle under constant per-frame gravity onto the screen floor.
- Holds it on the floor until a right click returns control to the mouse.
- All motion updates occur once per frame, on the vsync rising edge, so the drawn rectangle never tears mid-frame.

---
 rtl/draw_rect_pkg.sv | 22 ++
 rtl/frame_tick.sv | 25 ++
 rtl/draw_rect_ctl.sv | 146 ++++++++++++++
 tb/tb_draw_rect_ctl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/draw_rect_pkg.sv
// ============================================================================
// draw_rect_pkg : shared types and geometry for the rectangle draw pipeline
// Revision      : 1.0
// ============================================================================
`default_nettype none

package draw_rect_pkg;

  localparam int COORD_W         = 12;
  localparam int V_RES_DEF       = 600;
  localparam int RECT_HEIGHT_DEF = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FALLING = 2'd1,
    BOTTOM  = 2'd2,
    RISING  = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/frame_tick.sv
// ============================================================================
// frame_tick : one-cycle pulse on each rising edge of vsync_in
// Revision   : 1.0
// ============================================================================
`default_nettype none

module frame_tick (
  input  logic pclk,
  input  logic rst_n,
  input  logic vsync_in,
  output logic tick
);

  logic vsync_q;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) vsync_q <= 1'b0;
    else        vsync_q <= vsync_in;
  end

  assign tick = vsync_in & ~vsync_q;

endmodule

`default_nettype wire

// File: rtl/draw_rect_ctl.sv
// ============================================================================
// draw_rect_ctl : mouse-follow / gravity-drop position controller, updated
//                 once per frame on the vsync rising edge.
// Build option  : DRAW_RECT_CTL_BOUNCE_EN adds a bounce (RISING) phase.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module draw_rect_ctl
  import draw_rect_pkg::*;
#(
  parameter int V_RES          = V_RES_DEF,
  parameter int RECT_HEIGHT    = RECT_HEIGHT_DEF,
  parameter int GRAVITY        = 1,
  parameter int MAX_VEL        = 16
`ifdef DRAW_RECT_CTL_BOUNCE_EN
 ,parameter int BOUNCE_MIN_VEL = 4
`endif
) (
  input  logic               pclk,
  input  logic               rst_n,
  input  logic               vsync_in,
  input  logic [COORD_W-1:0] mouse_xpos,
  input  logic [COORD_W-1:0] mouse_ypos,
  input  logic               mouse_left,
  input  logic               mouse_right,
  output logic [COORD_W-1:0] xpos,
  output logic [COORD_W-1:0] ypos,
  output logic               falling
);

  localparam int VEL_W = 6;
  localparam logic [COORD_W:0]  FLOOR_Y = (COORD_W+1)'(V_RES - RECT_HEIGHT);
  localparam logic [VEL_W:0]    GRAV_W  = (VEL_W+1)'(GRAVITY);
  localparam logic [VEL_W:0]    MAXV_W  = (VEL_W+1)'(MAX_VEL);

  state_e             state_q, state_d;
  logic [COORD_W-1:0] xpos_q, xpos_d;
  logic [COORD_W-1:0] ypos_q, ypos_d;
  logic [VEL_W-1:0]   vel_q, vel_d;
  logic               falling_q, falling_d;
  logic               tick;

  logic [VEL_W:0]     vsum;
  logic [VEL_W-1:0]   vnew;
  logic [COORD_W:0]   ynew;
  logic [COORD_W-1:0] ymouse;

  frame_tick u_frame_tick (
    .pclk     (pclk),
    .rst_n    (rst_n),
    .vsync_in (vsync_in),
    .tick     (tick)
  );

  // 13-bit arithmetic so the floor compare never sees a wrapped sum
  assign vsum   = {1'b0, vel_q} + GRAV_W;
  assign vnew   = (vsum > MAXV_W) ? MAXV_W[VEL_W-1:0] : vsum[VEL_W-1:0];
  assign ynew   = {1'b0, ypos_q} + (COORD_W+1)'(vnew);
  assign ymouse = ({1'b0, mouse_ypos} > FLOOR_Y) ? FLOOR_Y[COORD_W-1:0] : mouse_ypos;

`ifdef DRAW_RECT_CTL_BOUNCE_EN
  localparam logic [VEL_W-1:0] BMIN_W = VEL_W'(BOUNCE_MIN_VEL);
  logic [VEL_W-1:0]   vdec;
  logic [COORD_W-1:0] yrise;
  assign vdec  = vel_q - GRAV_W[VEL_W-1:0];
  assign yrise = (ypos_q < COORD_W'(vdec)) ? '0 : ypos_q - COORD_W'(vdec);
`endif

  always_comb begin
    state_d = state_q;
    xpos_d  = xpos_q;
    ypos_d  = ypos_q;
    vel_d   = vel_q;
    if (tick) begin
      unique case (state_q)
        IDLE: begin
          xpos_d = mouse_xpos;
          ypos_d = ymouse;
          if (mouse_left) begin
            vel_d   = '0;
            state_d = FALLING;
          end
        end
        FALLING: begin
          vel_d = vnew;
          if (ynew >= FLOOR_Y) begin
            ypos_d  = FLOOR_Y[COORD_W-1:0];
`ifdef DRAW_RECT_CTL_BOUNCE_EN
            if (vnew >= BMIN_W) begin
              vel_d   = vnew >> 1;
              state_d = RISING;
            end else begin
              state_d = BOTTOM;
            end
`else
            state_d = BOTTOM;
`endif
          end else begin
            ypos_d = ynew[COORD_W-1:0];
          end
        end
        BOTTOM: begin
          vel_d = '0;
          if (mouse_right) state_d = IDLE;
        end
`ifdef DRAW_RECT_CTL_BOUNCE_EN
        RISING: begin
          if (vel_q <= GRAV_W[VEL_W-1:0]) begin
            vel_d   = '0;
            state_d = FALLING;
          end else begin
            vel_d  = vdec;
            ypos_d = yrise;
          end
        end
`endif
        default: state_d = IDLE;
      endcase
    end
    falling_d = (state_d == FALLING) || (state_d == RISING);
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      xpos_q    <= '0;
      ypos_q    <= '0;
      vel_q     <= '0;
      falling_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      xpos_q    <= xpos_d;
      ypos_q    <= ypos_d;
      vel_q     <= vel_d;
      falling_q <= falling_d;
    end
  end

  assign xpos    = xpos_q;
  assign ypos    = ypos_q;
  assign falling = falling_q;

endmodule

`default_nettype wire

// File: tb/tb_draw_rect_ctl.sv
// ============================================================================
// tb_draw_rect_ctl : directed bench for draw_rect_ctl
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_draw_rect_ctl;

  logic        pclk;
  logic        rst_n;
  logic        vsync_in;
  logic [11:0] mouse_xpos;
  logic [11:0] mouse_ypos;
  logic        mouse_left;
  logic        mouse_right;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        falling;

  int n_checks = 0;
  int n_fail   = 0;

  draw_rect_ctl dut (
    .pclk        (pclk),
    .rst_n       (rst_n),
    .vsync_in    (vsync_in),
    .mouse_xpos  (mouse_xpos),
    .mouse_ypos  (mouse_ypos),
    .mouse_left  (mouse_left),
    .mouse_right (mouse_right),
    .xpos        (xpos),
    .ypos        (ypos),
    .falling     (falling)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // vsync rises at a falling edge; outputs are sampled #1 after the next rising edge
  task automatic do_tick(input int hold);
    @(negedge pclk);
    vsync_in = 1'b1;
    @(posedge pclk);
    #1;
    repeat (hold) @(negedge pclk);
    vsync_in = 1'b0;
    @(negedge pclk);
  endtask

  task automatic set_mouse(input int x, input int y, input logic l, input logic r);
    mouse_xpos  = 12'(x);
    mouse_ypos  = 12'(y);
    mouse_left  = l;
    mouse_right = r;
  endtask

  int exp_drop [8] = '{501, 503, 506, 510, 515, 521, 528, 536};
  int exp_bnc  [5] = '{533, 531, 530, 530, 531};
  int guard;

  initial begin
    rst_n    = 1'b0;
    vsync_in = 1'b0;
    set_mouse(100, 200, 1'b0, 1'b0);

    // ---- reset with vsync toggling, then track ----
    for (int i = 0; i < 4; i++) begin
      @(negedge pclk); vsync_in = 1'b1;
      @(negedge pclk); vsync_in = 1'b0;
    end
    check("rst_xpos", 32'(xpos), 0);
    check("rst_ypos", 32'(ypos), 0);
    check("rst_falling", 32'(falling), 0);
    @(negedge pclk);
    rst_n = 1'b1;
    repeat (2) @(negedge pclk);
    vsync_in = 1'b1;
    #1;
    check("latency_hold_y", 32'(ypos), 0);
    @(posedge pclk);
    #1;
    check("track_x", 32'(xpos), 100);
    check("track_y", 32'(ypos), 200);
    vsync_in = 1'b0;
    set_mouse(7, 9, 1'b0, 1'b0);
    repeat (5) @(negedge pclk);
    check("between_ticks_x", 32'(xpos), 100);
    check("between_ticks_y", 32'(ypos), 200);

    // ---- drop from 500 ----
    set_mouse(100, 500, 1'b1, 1'b0);
    do_tick(2);
    check("click_y", 32'(ypos), 500);
    check("click_falling", 32'(falling), 1);
    set_mouse(300, 100, 1'b0, 1'b0);
`ifdef DRAW_RECT_CTL_BOUNCE_EN
    for (int i = 0; i < 8; i++) begin
      do_tick(2);
      check($sformatf("bdrop_y%0d", i), 32'(ypos), 32'(exp_drop[i]));
    end
    check("bounce_falling", 32'(falling), 1);
    for (int i = 0; i < 5; i++) begin
      do_tick(2);
      check($sformatf("bounce_y%0d", i), 32'(ypos), 32'(exp_bnc[i]));
      check($sformatf("bounce_f%0d", i), 32'(falling), 1);
    end
`else
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        // one long vsync pulse must advance motion exactly once
        @(negedge pclk);
        vsync_in = 1'b1;
        repeat (20) @(negedge pclk);
        check("long_vsync_y", 32'(ypos), 32'(exp_drop[i]));
        vsync_in = 1'b0;
        @(negedge pclk);
      end else begin
        do_tick(2);
      end
      check($sformatf("drop_y%0d", i), 32'(ypos), 32'(exp_drop[i]));
      check($sformatf("drop_x%0d", i), 32'(xpos), 100);
    end
    check("landed_falling", 32'(falling), 0);
`endif

    // ---- reset mid-fall ----
    rst_n = 1'b0;
    repeat (2) @(negedge pclk);
    rst_n = 1'b1;
    set_mouse(100, 500, 1'b1, 1'b0);
    do_tick(2);
    set_mouse(100, 500, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) do_tick(2);
    check("midfall_y", 32'(ypos), 510);
    @(negedge pclk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_x", 32'(xpos), 0);
    check("async_rst_y", 32'(ypos), 0);
    check("async_rst_falling", 32'(falling), 0);
    @(negedge pclk);
    rst_n = 1'b1;
    set_mouse(300, 300, 1'b0, 1'b0);
    do_tick(2);
    check("post_rst_idle_x", 32'(xpos), 300);
    check("post_rst_idle_f", 32'(falling), 0);

    // ---- velocity cap, drop from 0 ----
    set_mouse(50, 0, 1'b1, 1'b0);
    do_tick(1);
    set_mouse(50, 0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) do_tick(1);
    check("cap16_y", 32'(ypos), 136);
    do_tick(1);
    check("cap17_y", 32'(ypos), 152);
    do_tick(1);
    check("cap18_y", 32'(ypos), 168);
    guard = 0;
    while (falling && guard < 200) begin
      do_tick(1);
      guard++;
    end
    check("cap_land_timeout", 32'(falling), 0);
    check("cap_land_y", 32'(ypos), 536);

    // ---- button rules in BOTTOM ----
    set_mouse(60, 70, 1'b1, 1'b0);
    do_tick(1);
    check("bottom_left_y", 32'(ypos), 536);
    check("bottom_left_x", 32'(xpos), 50);
    check("bottom_left_f", 32'(falling), 0);
    set_mouse(60, 70, 1'b0, 1'b0);
    do_tick(1);
    check("bottom_hold_y", 32'(ypos), 536);
    set_mouse(60, 70, 1'b1, 1'b1);
    do_tick(1);
    check("both_btn_y", 32'(ypos), 536);
    check("both_btn_f", 32'(falling), 0);
    set_mouse(40, 300, 1'b0, 1'b0);
    do_tick(1);
    check("resume_x", 32'(xpos), 40);
    check("resume_y", 32'(ypos), 300);
    set_mouse(41, 590, 1'b0, 1'b0);
    do_tick(1);
    check("clamp_y", 32'(ypos), 536);
    check("clamp_x", 32'(xpos), 41);

    // ---- start at floor: first fall tick lands ----
    set_mouse(41, 536, 1'b1, 1'b0);
    do_tick(1);
    check("floor_click_f", 32'(falling), 1);
    set_mouse(41, 536, 1'b0, 1'b0);
    do_tick(1);
    check("floor_land_y", 32'(ypos), 536);
`ifndef DRAW_RECT_CTL_BOUNCE_EN
    check("floor_land_f", 32'(falling), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
